fifo_bank: RTL
==============

# fifo_bank

Parametrised single-clock bank of NUM_CH independent FIFO channels with programmable almost-full/almost-empty thresholds, per-channel occupancy counts, synchronous flush and first-word-fall-through outputs. It is the command/data buffering stage on the SDRAM-controller side of the AXI4-Lite bridge, downstream of the clock-domain-crossing FIFOs. One instance replaces the separate per-stream FIFOs for write address, write data, read address and the read/write flag, all clocked by SD_CLK.

## Interface
Parameters:
- WIDTH, 32: data bits per entry.
- DEPTH, 16: entries per channel; power of two, at least 2.
- NUM_CH, 4: number of independent channels, at least 1.
- AFULL_TH, DEPTH-2: ALMOST_FULL[c] is asserted when COUNT[c] >= AFULL_TH.
- AEMPTY_TH, 2: ALMOST_EMPTY[c] is asserted when COUNT[c] <= AEMPTY_TH.

Ports. Reset is synchronous and active-high. Vectors are packed, with channel c at bits [c*WIDTH +: WIDTH], or [c*CW +: CW] for counts, where CW = $clog2(DEPTH)+1.
- SD_CLK, in, 1: the only clock.
- SD_RST, in, 1: synchronous active-high reset.
- PUSH, in, NUM_CH: per-channel write strobe.
- DIN, in, NUM_CH*WIDTH: per-channel write data.
- POP, in, NUM_CH: per-channel read strobe; consumes the current head entry.
- FLUSH, in, NUM_CH: per-channel synchronous clear.
- ERR_CLR, in, 1: clears all sticky error flags.
- DOUT, out, NUM_CH*WIDTH: head entry of each channel, first-word-fall-through.
- COUNT, out, NUM_CH*CW: occupancy of each channel, from 0 to DEPTH.
- FULL, out, NUM_CH: asserted when COUNT[c] == DEPTH.
- EMPTY, out, NUM_CH: asserted when COUNT[c] == 0.
- ALMOST_FULL, out, NUM_CH: asserted when COUNT[c] >= AFULL_TH.
- ALMOST_EMPTY, out, NUM_CH: asserted when COUNT[c] <= AEMPTY_TH.
- OVF, out, NUM_CH: sticky flag, set by a push into a full channel.
- UDF, out, NUM_CH: sticky flag, set by a pop from an empty channel.

## Operation
Per channel:
- State is held in a write pointer, a read pointer (both $clog2(DEPTH) bits, wrapping modulo DEPTH) and a registered COUNT.
- All flags decode combinationally from the registered COUNT.
- Push is accepted when not FULL: write DIN to mem[wr_ptr], then increment wr_ptr.
- Pop is accepted when not EMPTY: increment rd_ptr.
- Simultaneous push and pop:
  - both are accepted whenever the channel is neither empty nor full;
  - when FULL, both are accepted because the pop frees the slot, and COUNT is unchanged;
  - when EMPTY, only the push is accepted, the pop is rejected, and UDF is set.
- Rejected push: data is dropped, no state changes except OVF.
- Rejected pop: no state changes except UDF.
- FLUSH[c] has priority over PUSH[c] and POP[c] in the same cycle. It zeroes both pointers and COUNT and does not alter OVF/UDF.
- DOUT[c] = mem[rd_ptr] when the channel is not EMPTY, else all zeros.
- Channels are fully independent; activity on one channel never affects another.
- ERR_CLR clears all OVF/UDF bits. A new error in the same cycle wins, and its flag is set.

Reset values:
- COUNT = 0, EMPTY = 1, ALMOST_EMPTY = 1.
- FULL = 0, ALMOST_FULL = 0 (for AFULL_TH > 0).
- OVF = 0, UDF = 0, DOUT = 0, pointers = 0.
- Memory contents are not reset.
- Reset in the middle of traffic discards all entries at the next clock edge.

## Timing
- Push in cycle n: the entry appears on DOUT, and EMPTY/COUNT update, from cycle n+1.
- Pop in cycle n: DOUT shows the next entry, or zero, from cycle n+1.
- Flags lag the triggering push/pop by exactly one cycle and have no combinational path from PUSH/POP.
- DOUT has no combinational path from DIN.
- Memory write is synchronous; head read is asynchronous from the register or LUT array.
- Sustained throughput is one push and one pop per channel per cycle.

## Configuration
- Macro FIFO_BANK_STICKY_ERR_EN.
- Defined: OVF/UDF registers and ERR_CLR behave as described above.
- Undefined: OVF and UDF are tied to 0, ERR_CLR is ignored, and no error registers are synthesised.
- Port list is identical in both builds.
- Push/pop acceptance rules do not change in either build.

## Structure
- Package fifo_bank_pkg holds:
  - the function computing CW from DEPTH;
  - the default threshold constants;
  - a channel-index enum naming the bridge streams: CH_WADDR = 0, CH_WDATA = 1, CH_RADDR = 2, CH_RW = 3.
- Sub-module fifo_bank_ch implements one channel (memory, pointers, count, flags, error bits). The top level contains only a generate loop over NUM_CH plus vector slicing.
- Elaboration-time assertions check:
  - DEPTH is a power of two;
  - AFULL_TH <= DEPTH;
  - AEMPTY_TH < DEPTH.

## Test plan
- **Reset:** assert SD_RST for 2 cycles mid-traffic. Required: all channels read COUNT = 0, EMPTY = 1, DOUT = 0, OVF = UDF = 0.
- **Fill and drain ordering (WIDTH=32, DEPTH=16):**
  - push 0xA0000000 through 0xA000000F on channel 0;
  - required: FULL after the 16th push, ALMOST_FULL at COUNT 14;
  - pop 16 times; required: data returns in order, EMPTY at the end, ALMOST_EMPTY at COUNT 2.
- **Full boundary:**
  - a 17th push with 0xDEAD is dropped, OVF[0] = 1, COUNT stays 16;
  - a simultaneous push of 0xBEEF and pop on the full channel leaves COUNT 16, and 0xBEEF is the last entry out.
- **Empty boundary:**
  - pop on an empty channel: UDF = 1, COUNT stays 0;
  - simultaneous push of 0x55 and pop on empty: COUNT = 1, DOUT = 0x55, UDF = 1;
  - ERR_CLR: OVF and UDF read 0.
- **Flush and independence:**
  - load 5 entries in channel 2 and 3 entries in channel 3;
  - FLUSH[2] together with PUSH[2]: channel 2 COUNT = 0, channel 3 unchanged at 3 with its data intact.
- **Build without macro:** repeat the two boundary tests. Required: OVF and UDF stay 0 and all data/count behaviour is identical.

Source files
------------

// File: rtl/fifo_bank_pkg.sv
// Shared constants and helpers for the fifo_bank command/data buffering stage.
// Holds the count-width function, default thresholds and bridge stream names.
package fifo_bank_pkg;

   // Count needs one extra bit so that a completely full channel (== DEPTH) is representable.
   function automatic int cw_of(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DEF_AFULL_MARGIN = 2;
   localparam int DEF_AEMPTY_TH    = 2;

   typedef enum logic [1:0] {
      CH_WADDR = 2'd0,
      CH_WDATA = 2'd1,
      CH_RADDR = 2'd2,
      CH_RW    = 2'd3
   } ch_e;

endpackage

// File: rtl/fifo_bank_ch.sv
// One first-word-fall-through FIFO channel: memory, pointers, registered count, flags.
// Sticky OVF/UDF registers exist only when FIFO_BANK_STICKY_ERR_EN is defined.
module fifo_bank_ch
   import fifo_bank_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   input  logic                     flush,
   input  logic                     err_clr,
   output logic [WIDTH-1:0]         dout,
   output logic [cw_of(DEPTH)-1:0]  count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     ovf,
   output logic                     udf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cw_of(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
   localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt;
   logic             push_ok, pop_ok;

   assign full         = (cnt == DEPTH_C);
   assign empty        = (cnt == '0);
   assign almost_full  = (cnt >= AF_C);
   assign almost_empty = (cnt <= AE_C);
   assign count        = cnt;
   assign dout         = empty ? '0 : mem[rd_ptr];

   // A pop on a full channel frees the slot the simultaneous push lands in.
   assign push_ok = push && !flush && (!full || pop);
   assign pop_ok  = pop  && !flush && !empty;

   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef FIFO_BANK_STICKY_ERR_EN
   logic ovf_q, udf_q;

   // A new error in the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (push && !flush && full && !pop) ovf_q <= 1'b1;
         else if (err_clr)                   ovf_q <= 1'b0;
         if (pop && !flush && empty)         udf_q <= 1'b1;
         else if (err_clr)                   udf_q <= 1'b0;
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`else
   logic err_clr_unused;
   assign err_clr_unused = err_clr;
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

endmodule

// File: rtl/fifo_bank.sv
// Bank of NUM_CH independent FIFO channels on the SD_CLK side of the AXI4-Lite bridge.
// Optional sticky OVF/UDF flags are built when FIFO_BANK_STICKY_ERR_EN is defined.
module fifo_bank
   import fifo_bank_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int NUM_CH    = 4,
   parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
)(
   input  logic                            SD_CLK,
   input  logic                            SD_RST,
   input  logic [NUM_CH-1:0]               PUSH,
   input  logic [NUM_CH*WIDTH-1:0]         DIN,
   input  logic [NUM_CH-1:0]               POP,
   input  logic [NUM_CH-1:0]               FLUSH,
   input  logic                            ERR_CLR,
   output logic [NUM_CH*WIDTH-1:0]         DOUT,
   output logic [NUM_CH*cw_of(DEPTH)-1:0]  COUNT,
   output logic [NUM_CH-1:0]               FULL,
   output logic [NUM_CH-1:0]               EMPTY,
   output logic [NUM_CH-1:0]               ALMOST_FULL,
   output logic [NUM_CH-1:0]               ALMOST_EMPTY,
   output logic [NUM_CH-1:0]               OVF,
   output logic [NUM_CH-1:0]               UDF
);
   localparam int CW = cw_of(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
      $error("fifo_bank: DEPTH must be a power of two and at least 2");
   end
   if (AFULL_TH > DEPTH) begin : g_chk_afull
      $error("fifo_bank: AFULL_TH must not exceed DEPTH");
   end
   if (AEMPTY_TH >= DEPTH) begin : g_chk_aempty
      $error("fifo_bank: AEMPTY_TH must be below DEPTH");
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fifo_bank_ch #(
         .WIDTH     (WIDTH),
         .DEPTH     (DEPTH),
         .AFULL_TH  (AFULL_TH),
         .AEMPTY_TH (AEMPTY_TH)
      ) u_ch (
         .clk          (SD_CLK),
         .rst          (SD_RST),
         .push         (PUSH[c]),
         .din          (DIN[c*WIDTH +: WIDTH]),
         .pop          (POP[c]),
         .flush        (FLUSH[c]),
         .err_clr      (ERR_CLR),
         .dout         (DOUT[c*WIDTH +: WIDTH]),
         .count        (COUNT[c*CW +: CW]),
         .full         (FULL[c]),
         .empty        (EMPTY[c]),
         .almost_full  (ALMOST_FULL[c]),
         .almost_empty (ALMOST_EMPTY[c]),
         .ovf          (OVF[c]),
         .udf          (UDF[c])
      );
   end

endmodule
